// File: rtl/usb_frame_flow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// usb_frame_flow_ctrl_pkg
//   Shared definitions for the imager-side controllers. It holds the common
//   FSM state encodings and the width of the externally reported frame count.
// ---------------------------------------------------------------------------
package usb_frame_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_RUN   = 2'd1,
    FSM_STALL = 2'd2,
    FSM_ERROR = 2'd3
  } fsm_state_e;

  // Width of the reported frames_avail count. The count saturates at its maximum value.
  localparam int FRAME_CNT_W = 4;
  localparam logic [FRAME_CNT_W-1:0] FRAMES_SAT = '1;

endpackage

// File: rtl/usb_frame_flow_ctrl_frame_word_cnt.sv
// ---------------------------------------------------------------------------
// usb_frame_flow_ctrl_frame_word_cnt
//   Modulo-N word counter. It counts the cycles in which en is high and wraps
//   to 0 after N counts. wrap is a combinational flag. It is high in the
//   cycle whose increment completes a frame. The parent can then update its
//   frame bookkeeping on the same edge that the counter wraps.
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   async active-low reset
//   clr    in   synchronous clear. It has priority over en.
//   en     in   count one word this cycle
//   wrap   out  this cycle's increment completes a frame
// ---------------------------------------------------------------------------
module usb_frame_flow_ctrl_frame_word_cnt #(
  parameter int N = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);
  assign wrap    = en && !clr && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_frame_flow_ctrl.sv
// ---------------------------------------------------------------------------
// usb_frame_flow_ctrl
//   Frame-level flow controller for the 24-bit USB output FIFO. The block
//   counts the words written into the FIFO and the words drained by the host
//   pipe. It reports the number of complete frames that are buffered. It asks
//   the imager to stall when MAX_FRAMES frames are buffered. It traps FIFO
//   overflow and FIFO underflow.
//
// Interface semantics: wr_valid and rd_en are single-cycle word strobes that
//   have no backpressure. Each cycle in which a strobe is high moves exactly
//   one word. fifo_full qualifies wr_valid in the same cycle. All outputs are
//   registered, so the effect of an input appears one cycle later.
//
// Ports
//   okClk        in   host-interface clock (rising edge)
//   rst_n        in   async active-low reset
//   enable       in   host run enable. 0 clears the counters and forces IDLE.
//   wr_valid     in   one word written into the USB FIFO
//   fifo_full    in   USB FIFO full flag
//   rd_en        in   one word popped by a pipe read
//   frame_ready  out  at least one complete frame is buffered
//   frames_avail out  complete frames buffered. Saturates at 15.
//   word_level   out  words buffered (writes minus reads)
//   stall_req    out  stop the imager FSM / exposure
//   ovf_trig     out  1-cycle pulse on a write while the FIFO is full
//   udf_trig     out  1-cycle pulse on a read while word_level is 0
//   state        out  FSM state (IDLE=0 RUN=1 STALL=2 ERROR=3)
// ---------------------------------------------------------------------------
module usb_frame_flow_ctrl
  import usb_frame_flow_ctrl_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 4096,
  parameter int MAX_FRAMES      = 2,
  parameter int LVL_W           = 18
) (
  input  logic                   okClk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   wr_valid,
  input  logic                   fifo_full,
  input  logic                   rd_en,
  output logic                   frame_ready,
  output logic [FRAME_CNT_W-1:0] frames_avail,
  output logic [LVL_W-1:0]       word_level,
  output logic                   stall_req,
  output logic                   ovf_trig,
  output logic                   udf_trig,
  output logic [1:0]             state
);

  localparam logic [FRAME_CNT_W-1:0] MAX_F = FRAME_CNT_W'(MAX_FRAMES);

  fsm_state_e             state_q, state_d;
  logic [LVL_W-1:0]       word_level_q, word_level_d;
  // The unsaturated frame difference. The buffered frames can never exceed
  // the buffered words, so LVL_W bits are enough to hold it without wrapping.
  logic [LVL_W-1:0]       diff_q, diff_d;
  logic [FRAME_CNT_W-1:0] frames_avail_q, frames_avail_d;
  logic                   frame_ready_q, frame_ready_d;
  logic                   stall_req_q, stall_req_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;

  logic active;
  logic clr;
  logic wr_cnt_en, rd_cnt_en;
  logic wr_wrap, rd_wrap;

  // Counting happens only in RUN or STALL. In IDLE the counters are held at
  // 0. In ERROR the counters are frozen.
  assign active = enable && ((state_q == FSM_RUN) || (state_q == FSM_STALL));
  assign clr    = !enable || (state_q == FSM_IDLE);

  assign ovf_d  = active && wr_valid && fifo_full;
  // A read at level 0 is legal when a write lands in the same cycle.
  assign udf_d  = active && rd_en && (word_level_q == '0) && !wr_valid;

  assign wr_cnt_en = active && wr_valid && !fifo_full;
  assign rd_cnt_en = active && rd_en && !udf_d;

  usb_frame_flow_ctrl_frame_word_cnt #(.N(WORDS_PER_FRAME)) u_wr_cnt (
    .clk   (okClk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (wr_cnt_en),
    .wrap  (wr_wrap)
  );

  usb_frame_flow_ctrl_frame_word_cnt #(.N(WORDS_PER_FRAME)) u_rd_cnt (
    .clk   (okClk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (rd_cnt_en),
    .wrap  (rd_wrap)
  );

  // Level and frame bookkeeping
  always_comb begin
    word_level_d = word_level_q;
    diff_d       = diff_q;
    if (clr) begin
      word_level_d = '0;
      diff_d       = '0;
    end else begin
      if (wr_cnt_en && !rd_cnt_en) begin
        word_level_d = word_level_q + LVL_W'(1);
      end else if (rd_cnt_en && !wr_cnt_en) begin
        word_level_d = word_level_q - LVL_W'(1);
      end
      if (wr_wrap && !rd_wrap) begin
        diff_d = diff_q + LVL_W'(1);
      end else if (rd_wrap && !wr_wrap) begin
        diff_d = diff_q - LVL_W'(1);
      end
    end
    frames_avail_d = (diff_d > LVL_W'(FRAMES_SAT)) ? FRAMES_SAT
                                                   : diff_d[FRAME_CNT_W-1:0];
    frame_ready_d  = (diff_d != '0);
  end

  // FSM next state. The transitions look at the next frame count, so that
  // stall_req rises on the same edge that frames_avail reaches MAX_FRAMES.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = FSM_IDLE;
    end else begin
      unique case (state_q)
        FSM_IDLE:  state_d = FSM_RUN;
        FSM_RUN: begin
          if (ovf_d || udf_d)               state_d = FSM_ERROR;
          else if (frames_avail_d >= MAX_F) state_d = FSM_STALL;
        end
        FSM_STALL: begin
          if (ovf_d || udf_d)              state_d = FSM_ERROR;
          else if (frames_avail_d < MAX_F) state_d = FSM_RUN;
        end
        FSM_ERROR: state_d = FSM_ERROR;
        default:   state_d = FSM_IDLE;
      endcase
    end
    stall_req_d = (state_d != FSM_RUN);
  end

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FSM_IDLE;
      word_level_q   <= '0;
      diff_q         <= '0;
      frames_avail_q <= '0;
      frame_ready_q  <= 1'b0;
      stall_req_q    <= 1'b0;
      ovf_q          <= 1'b0;
      udf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_level_q   <= word_level_d;
      diff_q         <= diff_d;
      frames_avail_q <= frames_avail_d;
      frame_ready_q  <= frame_ready_d;
      stall_req_q    <= stall_req_d;
      ovf_q          <= ovf_d;
      udf_q          <= udf_d;
    end
  end

  assign frame_ready  = frame_ready_q;
  assign frames_avail = frames_avail_q;
  assign word_level   = word_level_q;
  assign stall_req    = stall_req_q;
  assign ovf_trig     = ovf_q;
  assign udf_trig     = udf_q;
  assign state        = state_q;

endmodule

// File: tb/tb_usb_frame_flow_ctrl.sv
module tb_usb_frame_flow_ctrl;

  localparam int WPF   = 8;
  localparam int MAXF  = 2;
  localparam int LVL_W = 18;

  // clock / reset
  logic okClk = 1'b0;
  logic rst_n = 1'b1;
  always #5 okClk = ~okClk;

  logic             enable    = 1'b0;
  logic             wr_valid  = 1'b0;
  logic             fifo_full = 1'b0;
  logic             rd_en     = 1'b0;
  logic             frame_ready;
  logic [3:0]       frames_avail;
  logic [LVL_W-1:0] word_level;
  logic             stall_req;
  logic             ovf_trig;
  logic             udf_trig;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  usb_frame_flow_ctrl #(
    .WORDS_PER_FRAME (WPF),
    .MAX_FRAMES      (MAXF),
    .LVL_W           (LVL_W)
  ) dut (
    .okClk        (okClk),
    .rst_n        (rst_n),
    .enable       (enable),
    .wr_valid     (wr_valid),
    .fifo_full    (fifo_full),
    .rd_en        (rd_en),
    .frame_ready  (frame_ready),
    .frames_avail (frames_avail),
    .word_level   (word_level),
    .stall_req    (stall_req),
    .ovf_trig     (ovf_trig),
    .udf_trig     (udf_trig),
    .state        (state)
  );

  // driver tasks: inputs change 1 time unit after the active edge, and
  // outputs are sampled at that same point, well away from the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge okClk);
      #1;
    end
  endtask

  task automatic write_words(input int n);
    wr_valid = 1'b1;
    tick(n);
    wr_valid = 1'b0;
  endtask

  task automatic read_words(input int n);
    rd_en = 1'b1;
    tick(n);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall_req); end
    checks++; if (frames_avail !== 4'd0 || frame_ready !== 1'b0) begin errors++; $display("FAIL reset_frames got %0d/%0b exp 0/0", frames_avail, frame_ready); end
    checks++; if (word_level !== '0 || ovf_trig !== 1'b0 || udf_trig !== 1'b0) begin errors++; $display("FAIL reset_level_trig got %0d/%0b/%0b exp 0/0/0", word_level, ovf_trig, udf_trig); end
    #3 rst_n = 1'b1;
    tick(1);
    checks++; if (state !== 2'd0 || stall_req !== 1'b1) begin errors++; $display("FAIL idle_stall got state %0d stall %0b exp 0/1", state, stall_req); end
  endtask

  task automatic test_single_frame();
    enable = 1'b1;
    tick(1);
    checks++; if (state !== 2'd1 || stall_req !== 1'b0) begin errors++; $display("FAIL run_entry got state %0d stall %0b exp 1/0", state, stall_req); end
    write_words(7);
    checks++; if (word_level !== 18'd7 || frame_ready !== 1'b0 || frames_avail !== 4'd0) begin errors++; $display("FAIL partial_frame got lvl %0d rdy %0b fa %0d exp 7/0/0", word_level, frame_ready, frames_avail); end
    write_words(1);
    checks++; if (frames_avail !== 4'd1 || frame_ready !== 1'b1) begin errors++; $display("FAIL first_frame got fa %0d rdy %0b exp 1/1", frames_avail, frame_ready); end
    checks++; if (word_level !== 18'd8 || state !== 2'd1) begin errors++; $display("FAIL first_frame_lvl got lvl %0d state %0d exp 8/1", word_level, state); end
  endtask

  task automatic test_stall();
    write_words(8);
    checks++; if (frames_avail !== 4'd2 || stall_req !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL stall_entry got fa %0d stall %0b state %0d exp 2/1/2", frames_avail, stall_req, state); end
    checks++; if (word_level !== 18'd16) begin errors++; $display("FAIL stall_lvl got %0d exp 16", word_level); end
    read_words(8);
    checks++; if (frames_avail !== 4'd1 || state !== 2'd1 || stall_req !== 1'b0) begin errors++; $display("FAIL stall_exit got fa %0d state %0d stall %0b exp 1/1/0", frames_avail, state, stall_req); end
    checks++; if (word_level !== 18'd8) begin errors++; $display("FAIL stall_exit_lvl got %0d exp 8", word_level); end
  endtask

  task automatic test_back_to_back();
    wr_valid = 1'b1;
    rd_en    = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      checks++; if (frames_avail !== 4'd1 || word_level !== 18'd8) begin errors++; $display("FAIL b2b_cycle%0d got fa %0d lvl %0d exp 1/8", i, frames_avail, word_level); end
    end
    wr_valid = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic test_overflow();
    wr_valid  = 1'b1;
    fifo_full = 1'b1;
    tick(1);
    checks++; if (ovf_trig !== 1'b1 || state !== 2'd3 || stall_req !== 1'b1) begin errors++; $display("FAIL ovf_hit got ovf %0b state %0d stall %0b exp 1/3/1", ovf_trig, state, stall_req); end
    checks++; if (word_level !== 18'd8 || frames_avail !== 4'd1) begin errors++; $display("FAIL ovf_not_counted got lvl %0d fa %0d exp 8/1", word_level, frames_avail); end
    fifo_full = 1'b0;
    rd_en     = 1'b1;
    tick(1);
    checks++; if (ovf_trig !== 1'b0 || state !== 2'd3) begin errors++; $display("FAIL ovf_pulse_sticky got ovf %0b state %0d exp 0/3", ovf_trig, state); end
    checks++; if (word_level !== 18'd8 || frames_avail !== 4'd1) begin errors++; $display("FAIL error_frozen got lvl %0d fa %0d exp 8/1", word_level, frames_avail); end
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    enable   = 1'b0;
    tick(1);
    checks++; if (state !== 2'd0 || word_level !== '0 || frames_avail !== 4'd0 || frame_ready !== 1'b0 || stall_req !== 1'b1) begin errors++; $display("FAIL error_exit got state %0d lvl %0d fa %0d rdy %0b stall %0b exp 0/0/0/0/1", state, word_level, frames_avail, frame_ready, stall_req); end
  endtask

  task automatic test_underflow();
    enable = 1'b1;
    tick(1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    checks++; if (udf_trig !== 1'b1 || state !== 2'd3 || word_level !== '0) begin errors++; $display("FAIL udf_hit got udf %0b state %0d lvl %0d exp 1/3/0", udf_trig, state, word_level); end
    tick(1);
    checks++; if (udf_trig !== 1'b0 || state !== 2'd3) begin errors++; $display("FAIL udf_pulse got udf %0b state %0d exp 0/3", udf_trig, state); end
    enable = 1'b0;
    tick(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL udf_exit got state %0d exp 0", state); end
  endtask

  task automatic test_saturation();
    enable = 1'b1;
    tick(1);
    write_words(16 * WPF);
    checks++; if (frames_avail !== 4'd15 || word_level !== 18'd128 || state !== 2'd2) begin errors++; $display("FAIL sat_high got fa %0d lvl %0d state %0d exp 15/128/2", frames_avail, word_level, state); end
    read_words(WPF);
    checks++; if (frames_avail !== 4'd15) begin errors++; $display("FAIL sat_hold got fa %0d exp 15", frames_avail); end
    read_words(WPF);
    checks++; if (frames_avail !== 4'd14 || word_level !== 18'd112 || state !== 2'd2) begin errors++; $display("FAIL sat_release got fa %0d lvl %0d state %0d exp 14/112/2", frames_avail, word_level, state); end
    enable = 1'b0;
    tick(1);
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    tick(1);
    write_words(5);
    checks++; if (word_level !== 18'd5) begin errors++; $display("FAIL pre_reset_lvl got %0d exp 5", word_level); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (word_level !== '0 || state !== 2'd0 || stall_req !== 1'b0 || frames_avail !== 4'd0) begin errors++; $display("FAIL async_reset got lvl %0d state %0d stall %0b fa %0d exp 0/0/0/0", word_level, state, stall_req, frames_avail); end
    #1 rst_n = 1'b1;
    tick(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL post_reset_run got %0d exp 1", state); end
    write_words(8);
    checks++; if (frames_avail !== 4'd1 || word_level !== 18'd8 || frame_ready !== 1'b1) begin errors++; $display("FAIL post_reset_frame got fa %0d lvl %0d rdy %0b exp 1/8/1", frames_avail, word_level, frame_ready); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_underflow();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
